// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - decode, ALU and writeback signals of the issue stage
// slave is the issue stage; master is the surrounding decode/ALU/writeback side.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;

  logic [XLEN-1:0] alu_operand_a;
  logic [XLEN-1:0] alu_operand_b;
  logic [1:0]      alu_control;
  logic [XLEN-1:0] alu_result;
  logic [1:0]      alu_compare;
  logic            alu_overflow;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_overflow;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_a, in_b,
    output in_ready,
    output alu_operand_a, alu_operand_b, alu_control,
    input  alu_result, alu_compare, alu_overflow,
    output out_valid, out_rd, out_data, out_overflow,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_a, in_b,
    input  in_ready,
    input  alu_operand_a, alu_operand_b, alu_control,
    output alu_result, alu_compare, alu_overflow,
    input  out_valid, out_rd, out_data, out_overflow,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - execute-stage sequencer around an external combinational ALU
// E holds the operation driving the ALU; W holds the finished result offered to writeback.
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave bus
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  logic            e_valid_q, e_valid_d;
  logic [1:0]      e_op_q, e_op_d;
  logic [4:0]      e_rd_q, e_rd_d;
  logic [XLEN-1:0] e_a_q, e_a_d;
  logic [XLEN-1:0] e_b_q, e_b_d;
  logic [CW-1:0]   e_cnt_q, e_cnt_d;

  logic            w_valid_q, w_valid_d;
  logic [4:0]      w_rd_q, w_rd_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic            w_ovf_q, w_ovf_d;

  logic            e_done;
  logic            move;
  logic            in_ready_w;
  logic            accept;
  logic [XLEN-1:0] e_res_data;
  logic            e_res_ovf;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  always_comb begin
    e_done     = e_valid_q && ((e_op_q != OP_MUL) || (e_cnt_q == '0));
    move       = e_done && (!w_valid_q || bus.out_ready);
    in_ready_w = !rst && (!e_valid_q || move);
    accept     = bus.in_valid && in_ready_w;
  end

  // Only the ALU outputs relevant to the op in E are sampled; the others are don't-care.
  always_comb begin
    e_res_data = bus.alu_result;
    e_res_ovf  = 1'b0;
    case (e_op_q)
      OP_ADD, OP_SUB: e_res_ovf = bus.alu_overflow;
      OP_CMP:         e_res_data = {{(XLEN-2){1'b0}}, bus.alu_compare};
      default:        e_res_data = bus.alu_result;
    endcase
  end

  // The completing E result beats W, since it is the younger write to the same register.
  always_comb begin
    fwd_a = bus.in_a;
    if (bus.in_rs1 != 5'd0) begin
      if (move && (e_rd_q == bus.in_rs1)) begin
        fwd_a = e_res_data;
      end else if (w_valid_q && (w_rd_q == bus.in_rs1)) begin
        fwd_a = w_data_q;
      end
    end
    fwd_b = bus.in_b;
    if (bus.in_rs2 != 5'd0) begin
      if (move && (e_rd_q == bus.in_rs2)) begin
        fwd_b = e_res_data;
      end else if (w_valid_q && (w_rd_q == bus.in_rs2)) begin
        fwd_b = w_data_q;
      end
    end
  end

  always_comb begin
    e_valid_d = e_valid_q;
    e_op_d    = e_op_q;
    e_rd_d    = e_rd_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    e_cnt_d   = e_cnt_q;
    if (accept) begin
      e_valid_d = 1'b1;
      e_op_d    = bus.in_op;
      e_rd_d    = bus.in_rd;
      e_a_d     = fwd_a;
      e_b_d     = fwd_b;
      e_cnt_d   = (bus.in_op == OP_MUL) ? MUL_LOAD : '0;
    end else if (move) begin
      e_valid_d = 1'b0;
      e_op_d    = 2'b00;
      e_rd_d    = 5'd0;
      e_a_d     = '0;
      e_b_d     = '0;
      e_cnt_d   = '0;
    end else if (e_valid_q && (e_cnt_q != '0)) begin
      e_cnt_d = e_cnt_q - 1'b1;
    end
  end

  always_comb begin
    w_valid_d = w_valid_q;
    w_rd_d    = w_rd_q;
    w_data_d  = w_data_q;
    w_ovf_d   = w_ovf_q;
    if (move) begin
      w_valid_d = 1'b1;
      w_rd_d    = e_rd_q;
      w_data_d  = e_res_data;
      w_ovf_d   = e_res_ovf;
    end else if (w_valid_q && bus.out_ready) begin
      w_valid_d = 1'b0;
      w_rd_d    = 5'd0;
      w_data_d  = '0;
      w_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      e_op_q    <= 2'b00;
      e_rd_q    <= 5'd0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      e_cnt_q   <= '0;
      w_valid_q <= 1'b0;
      w_rd_q    <= 5'd0;
      w_data_q  <= '0;
      w_ovf_q   <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_op_q    <= e_op_d;
      e_rd_q    <= e_rd_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      e_cnt_q   <= e_cnt_d;
      w_valid_q <= w_valid_d;
      w_rd_q    <= w_rd_d;
      w_data_q  <= w_data_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.alu_operand_a = e_a_q;
  assign bus.alu_operand_b = e_b_q;
  assign bus.alu_control   = e_op_q;
  assign bus.out_valid     = w_valid_q;
  assign bus.out_rd        = w_rd_q;
  assign bus.out_data      = w_data_q;
  assign bus.out_overflow  = w_ovf_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - bench for alu_issue_stage
// Table-driven issue stream plus hand sequences, checked through a result scoreboard.
module tb_alu_issue_stage;
  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 2;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, CMP = 2'b10, MUL = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[21];

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(XLEN)) bus ();

  alu_issue_stage #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference ALU; overflow is forced high for cmp/mul so a stage that samples it there is caught.
  logic [31:0] m_a, m_b, m_sum, m_diff;
  assign m_a    = bus.alu_operand_a;
  assign m_b    = bus.alu_operand_b;
  assign m_sum  = m_a + m_b;
  assign m_diff = m_a - m_b;

  always_comb begin
    bus.alu_result   = 32'h0;
    bus.alu_overflow = 1'b0;
    bus.alu_compare  = 2'b11;
    case (bus.alu_control)
      2'b00: begin
        bus.alu_result   = m_sum;
        bus.alu_overflow = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
      end
      2'b01: begin
        bus.alu_result   = m_diff;
        bus.alu_overflow = (m_a[31] != m_b[31]) && (m_diff[31] != m_a[31]);
      end
      2'b10: begin
        bus.alu_result   = 32'hDEAD_BEEF;
        bus.alu_overflow = 1'b1;
        if (m_a > m_b)      bus.alu_compare = 2'b10;
        else if (m_a < m_b) bus.alu_compare = 2'b01;
        else                bus.alu_compare = 2'b00;
      end
      default: begin
        bus.alu_result   = m_a * m_b;
        bus.alu_overflow = 1'b1;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got rd=%0d data=%h, expected no output", bus.out_rd, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_rd", 32'(bus.out_rd), 32'(e.rd));
        check("out_data", bus.out_data, e.data);
        check("out_overflow", 32'(bus.out_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic issue(input vec_t v);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_rd    = v.rd;
    bus.in_rs1   = v.rs1;
    bus.in_rs2   = v.rs2;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) exp_q.push_back('{rd: v.rd, data: v.exp_data, ovf: v.exp_ovf});
    else begin
      n_checks++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] d, input logic o);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.a = a; v.b = b; v.exp_data = d; v.exp_ovf = o;
    return v;
  endfunction

  initial begin
    // Sources 24..31 are never written, so only deliberate dependencies forward.
    tbl[0]  = mk(SUB, 5'd4,  5'd24, 5'd25, 32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0);
    tbl[1]  = mk(CMP, 5'd6,  5'd24, 5'd25, 32'd9,        32'd4,        32'd2,         1'b0);
    tbl[2]  = mk(CMP, 5'd7,  5'd24, 5'd25, 32'd4,        32'd9,        32'd1,         1'b0);
    tbl[3]  = mk(CMP, 5'd8,  5'd24, 5'd25, 32'd8,        32'd8,        32'd0,         1'b0);
    tbl[4]  = mk(ADD, 5'd1,  5'd24, 5'd25, 32'd2,        32'd3,        32'd5,         1'b0);
    tbl[5]  = mk(ADD, 5'd2,  5'd1,  5'd26, 32'd0,        32'd10,       32'd15,        1'b0);
    tbl[6]  = mk(ADD, 5'd9,  5'd2,  5'd0,  32'd0,        32'd100,      32'd115,       1'b0);
    tbl[7]  = mk(ADD, 5'd0,  5'd24, 5'd25, 32'd1,        32'd1,        32'd2,         1'b0);
    tbl[8]  = mk(ADD, 5'd11, 5'd0,  5'd0,  32'd7,        32'd8,        32'd15,        1'b0);
    tbl[9]  = mk(ADD, 5'd12, 5'd24, 5'd25, 32'd1,        32'd1,        32'd2,         1'b0);
    tbl[10] = mk(ADD, 5'd13, 5'd26, 5'd27, 32'd3,        32'd4,        32'd7,         1'b0);
    tbl[11] = mk(ADD, 5'd14, 5'd12, 5'd13, 32'd0,        32'd0,        32'd9,         1'b0);
    tbl[12] = mk(ADD, 5'd15, 5'd24, 5'd25, 32'd10,       32'd0,        32'd10,        1'b0);
    tbl[13] = mk(ADD, 5'd15, 5'd24, 5'd25, 32'd20,       32'd0,        32'd20,        1'b0);
    tbl[14] = mk(ADD, 5'd16, 5'd15, 5'd0,  32'd0,        32'd1,        32'd21,        1'b0);
    tbl[15] = mk(SUB, 5'd17, 5'd24, 5'd25, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b1);
    tbl[16] = mk(MUL, 5'd18, 5'd24, 5'd25, 32'd7,        32'd6,        32'd42,        1'b0);
    tbl[17] = mk(MUL, 5'd19, 5'd24, 5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,       1'b0);
    tbl[18] = mk(ADD, 5'd20, 5'd24, 5'd25, 32'hFFFF_FFFF, 32'd1,       32'd0,         1'b0);
    tbl[19] = mk(CMP, 5'd21, 5'd26, 5'd27, 32'd0,        32'hFFFF_FFFF, 32'd1,        1'b0);
    tbl[20] = mk(ADD, 5'd22, 5'd24, 5'd25, 32'h8000_0000, 32'h8000_0000, 32'd0,       1'b1);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_alu_a", bus.alu_operand_a, 32'd0);
    check("rst_alu_ctl", 32'(bus.alu_control), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    issue(mk(ADD, 5'd3, 5'd24, 5'd25, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1));
    check("add_lat_t", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("add_lat_t1", 32'(bus.out_valid), 32'd1);
    wait_idle("drain_add");

    issue(mk(MUL, 5'd5, 5'd24, 5'd25, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0));
    check("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
    check("mul_lat_t", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("mul_done_in_ready", 32'(bus.in_ready), 32'd1);
    check("mul_lat_t1", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("mul_lat_t2", 32'(bus.out_valid), 32'd1);
    wait_idle("drain_mul");

    for (int i = 0; i < 21; i++) issue(tbl[i]);
    wait_idle("drain_table");

    bus.out_ready = 1'b0;
    issue(mk(ADD, 5'd21, 5'd24, 5'd25, 32'd1, 32'd2, 32'd3, 1'b0));
    issue(mk(SUB, 5'd22, 5'd24, 5'd25, 32'd10, 32'd3, 32'd7, 1'b0));
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", bus.out_data, 32'd3);
      check("bp_hold_rd", 32'(bus.out_rd), 32'd21);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_alu_a", bus.alu_operand_a, 32'd10);
      check("bp_hold_alu_ctl", 32'(bus.alu_control), 32'(SUB));
    end
    bus.out_ready = 1'b1;
    wait_idle("drain_bp");

    issue(mk(MUL, 5'd23, 5'd24, 5'd25, 32'd3, 32'd3, 32'd9, 1'b0));
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mid_alu_ctl", 32'(bus.alu_control), 32'd0);
    check("rst_mid_alu_a", bus.alu_operand_a, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    issue(mk(ADD, 5'd5, 5'd24, 5'd25, 32'd6, 32'd7, 32'd13, 1'b0));
    wait_idle("drain_after_rst");

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage sequencer that feeds the combinational ALU and collects its outputs. It accepts decoded operations from the decode stage over a valid/ready handshake and holds them in an operand register (E) that drives the ALU. It captures the ALU result, compare code and overflow flag into a result register (W), and hands that register to writeback over a second valid/ready handshake. It forwards W and completing-E results to back-to-back dependent operations and sequences multiplies over a fixed number of cycles.

## Interface
- XLEN, 32: operand/result width.
- MUL_CYCLES, 2: cycles a multiply occupies E (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode offers an operation.
- in_ready  out  1  stage accepts this cycle.
- in_op  in  2  00 add, 01 sub, 10 compare, 11 multiply.
- in_rd / in_rs1 / in_rs2  in  5 each  destination and source register numbers.
- in_a / in_b  in  XLEN each  register-file values for rs1/rs2.
- alu_operand_a / alu_operand_b  out  XLEN each  to ALU.
- alu_control  out  2  to ALU; same encoding as in_op.
- alu_result  in  XLEN  ALU sum/difference/product.
- alu_compare  in  2  00 equal, 10 A>B, 01 A<B (unsigned).
- alu_overflow  in  1  signed overflow for add/sub.
- out_valid  out  1  W holds a result.
- out_ready  in  1  writeback accepts.
- out_rd  out  5  destination register.
- out_data  out  XLEN  result.
- out_overflow  out  1  overflow flag of that result.

## Operation
- E register fields: e_valid, op, rd, rs1 value, rs2 value, mul counter. The ALU outputs are driven from E: alu_operand_a/b come from the stored values, and alu_control from the stored op.
- e_done condition:
  - add/sub/compare: e_done=1 in the first cycle e_valid=1.
  - multiply: e_done=1 once the counter reaches 0. The counter loads MUL_CYCLES-1 on accept and decrements each cycle while nonzero.
- E result mapping:
  - add/sub: data=alu_result, ovf=alu_overflow.
  - multiply: data=alu_result (low XLEN bits), ovf=0.
  - compare: data={XLEN-2 zeros, alu_compare}, ovf=0.
  - alu_compare is sampled only for compare. alu_overflow is sampled only for add/sub.
- Move condition: move = e_valid & e_done & (!out_valid | out_ready). On move, W loads rd, data and ovf, and W becomes valid.
- W clear: when out_valid & out_ready and there is no move, W clears.
- in_ready = !rst & (!e_valid | move). On accept (in_valid & in_ready), E loads the new operation. Otherwise E clears on move.
- Forwarding is evaluated per source at accept, only when rs≠0. Priority:
  1. E result being moved this cycle, when rs==E.rd.
  2. W data, when out_valid & rs==out_rd. This applies even if W is being drained this cycle.
  3. in_a/in_b.
- No other hazard exists. A busy multiply holds in_ready low, so no dependent operation can be accepted behind it.

## Timing
- Reset values: e_valid=0, all E fields 0, W fields 0, out_valid=0, in_ready=0 while rst is high, alu_* outputs=0.
- Reset mid-operation discards E and W contents immediately (asynchronously). No result is emitted for them.
- Latency: accept at edge t; out_valid is high after edge t+1 for add/sub/compare, and after edge t+MUL_CYCLES for multiply.
- Throughput is 1 operation/cycle for non-multiplies with out_ready=1. A multiply blocks input for MUL_CYCLES-1 extra cycles.
- Backpressure: with out_ready=0 and W full, E holds its operation and the ALU inputs stay stable. in_ready drops one cycle after E fills.
- out_rd, out_data and out_overflow are stable while out_valid=1 and out_ready=0.
- Simultaneous drain and move in the same cycle: W is overwritten with the new result and out_valid stays 1.
- Arithmetic wraps modulo 2^XLEN. Compare is unsigned.

## Test plan
- Reset, then add 0x7FFFFFFF+0x00000001 to rd=3, out_ready=1 -> one cycle after accept, out_data=0x80000000, out_overflow=1, out_rd=3.
- Sub 5-7 to rd=4 with out_ready=1 -> out_data=0xFFFFFFFE, out_overflow=0. Then compare 9 vs 4 -> out_data=0x00000002.
- Multiply 0x10000×0x10000 with MUL_CYCLES=2 -> in_ready=0 for one cycle, out_data=0x00000000, out_overflow=0, out_valid two edges after accept.
- Back-to-back dependency: add r1=2+3, then add r2=r1+10 with stale in_a=0 -> second out_data=15 via E-result forwarding. Any rs=0 case uses in_a/in_b.
- out_ready held 0 for 3 cycles with two operations issued -> W and E hold, in_ready=0, outputs stable. Release -> results appear in order, no loss or duplication.
- Assert rst during a multiply -> out_valid=0 and e_valid=0 immediately. After release, in_ready=1 and the next add completes normally.
